// File: rtl/if_fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_stage_pkg;

  localparam int unsigned MIPS_WORD_W = 32;

  localparam logic [MIPS_WORD_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [MIPS_WORD_W-1:0] NOP_WORD         = 32'h0000_0000;
  localparam logic [MIPS_WORD_W-1:0] PC_STEP          = 32'd4;

  // Fetch sequencer: REQ issues a read, WAIT holds until the single response returns.
  typedef enum logic {
    ST_REQ  = 1'b0,
    ST_WAIT = 1'b1
  } fetch_state_e;

  // One fetched instruction as handed to ID.
  typedef struct packed {
    logic [MIPS_WORD_W-1:0] instr;
    logic [MIPS_WORD_W-1:0] pc_plus4;
  } fetch_word_t;

endpackage

// File: rtl/if_fetch_stage_skid.sv
// if_skid_buffer: single-entry {instr, pc_plus4} holding slot for a response that
// lands while ID is stalled on a live output register.
module if_skid_buffer
  import if_fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        pop_i,
  input  logic        flush_i,
  input  fetch_word_t data_i,
  output logic        full_o,
  output fetch_word_t data_o
);

  logic        full_q, full_d;
  fetch_word_t data_q, data_d;

  // Next-state: pop/flush empty the slot, load fills it (flush wins over load).
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (pop_i || flush_i) begin
      full_d = 1'b0;
    end
    if (load_i && !flush_i) begin
      full_d = 1'b1;
      data_d = data_i;
    end
  end

  // Slot storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;

endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: owns the PC, keeps one instruction-memory read in flight, and
// presents {instruction, pc_plus4, valid} to ID through an output register plus
// a one-entry skid buffer.
// Build option: define DELAY_SLOT_EN for MIPS branch-delay-slot redirect handling;
// without it every younger instruction is squashed on redirect.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [MIPS_WORD_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   imem_req,
  output logic [MIPS_WORD_W-1:0] imem_addr,
  input  logic                   imem_rvalid,
  input  logic [MIPS_WORD_W-1:0] imem_rdata,
  input  logic                   redirect_valid,
  input  logic [MIPS_WORD_W-1:0] redirect_pc,
  input  logic                   id_stall,
  output logic                   if_id_valid,
  output logic [MIPS_WORD_W-1:0] if_id_instruction,
  output logic [MIPS_WORD_W-1:0] if_id_pc_plus4
);

  fetch_state_e           state_q, state_d;
  logic [MIPS_WORD_W-1:0] fetch_pc_q, fetch_pc_d;
  logic                   valid_q, valid_d;
  fetch_word_t            out_q, out_d;

  logic        skid_full, skid_load, skid_pop, skid_flush;
  fetch_word_t skid_data;
  fetch_word_t land_word;
  logic        issue, resp, land, consume;

  assign issue   = (state_q == ST_REQ) && !skid_full;
  assign resp    = (state_q == ST_WAIT) && imem_rvalid;
  assign consume = valid_q && !id_stall;

  // The outstanding request is always for fetch_pc_q, so the response tags from it.
  always_comb begin
    land_word          = '0;
    land_word.instr    = imem_rdata;
    land_word.pc_plus4 = fetch_pc_q + PC_STEP;
  end

`ifdef DELAY_SLOT_EN
  // The delay-slot word is kept, so every response is delivered.
  assign land       = resp;
  assign skid_flush = 1'b0;
`else
  logic kill_q, kill_d;
  // Killed (pre-redirect) responses and a response racing the redirect are wrong-path.
  assign land       = resp && !kill_q && !redirect_valid;
  assign skid_flush = redirect_valid;
`endif

  // Steer a landing response into the output register or the skid buffer.
  always_comb begin
    valid_d   = valid_q;
    out_d     = out_q;
    skid_load = 1'b0;
    skid_pop  = 1'b0;
    if (consume) begin
      if (skid_full) begin
        out_d    = skid_data;
        skid_pop = 1'b1;
      end else if (land) begin
        out_d = land_word;
      end else begin
        valid_d = 1'b0;
      end
    end else if (!valid_q) begin
      if (land) begin
        valid_d = 1'b1;
        out_d   = land_word;
      end
    end else if (land) begin
      skid_load = 1'b1;
    end
`ifndef DELAY_SLOT_EN
    if (redirect_valid) begin
      valid_d = 1'b0;
    end
`endif
  end

`ifdef DELAY_SLOT_EN
  logic                   pend_q, pend_d;
  logic [MIPS_WORD_W-1:0] pend_pc_q, pend_pc_d;

  // Sequencer and PC. The next sequential (delay-slot) word is either already in the
  // skid, landing now, or the next response; the target is applied once it is taken.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pend_d     = pend_q;
    pend_pc_d  = pend_pc_q;
    case (state_q)
      ST_REQ:  if (issue) state_d = ST_WAIT;
      ST_WAIT: begin
        if (imem_rvalid) begin
          state_d = ST_REQ;
          if (pend_q) begin
            fetch_pc_d = pend_pc_q;
            pend_d     = 1'b0;
          end else begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
          end
        end
      end
    endcase
    if (redirect_valid) begin
      if (skid_full || resp) begin
        fetch_pc_d = redirect_pc;
        pend_d     = 1'b0;
      end else begin
        pend_d    = 1'b1;
        pend_pc_d = redirect_pc;
      end
    end
  end

  // Pending redirect target register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
    end else begin
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
    end
  end
`else
  // Sequencer and PC. A redirect that leaves a request in flight marks it for dropping.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    kill_d     = kill_q;
    case (state_q)
      ST_REQ:  if (issue) state_d = ST_WAIT;
      ST_WAIT: begin
        if (imem_rvalid) begin
          state_d = ST_REQ;
          kill_d  = 1'b0;
          if (land) fetch_pc_d = fetch_pc_q + PC_STEP;
        end
      end
    endcase
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      kill_d     = (state_d == ST_WAIT);
    end
  end

  // Kill flag for the in-flight wrong-path request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kill_q <= 1'b0;
    end else begin
      kill_q <= kill_d;
    end
  end
`endif

  // Sequencer state, PC and ID-facing output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_REQ;
      fetch_pc_q <= RESET_PC;
      valid_q    <= 1'b0;
      out_q      <= '{instr: NOP_WORD, pc_plus4: '0};
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      valid_q    <= valid_d;
      out_q      <= out_d;
    end
  end

  if_skid_buffer u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (skid_load),
    .pop_i   (skid_pop),
    .flush_i (skid_flush),
    .data_i  (land_word),
    .full_o  (skid_full),
    .data_o  (skid_data)
  );

  // REQ is the reset state, so the request is masked while reset is held low.
  assign imem_req          = issue && rst_n;
  assign imem_addr         = fetch_pc_q;
  assign if_id_valid       = valid_q;
  assign if_id_instruction = out_q.instr;
  assign if_id_pc_plus4    = out_q.pc_plus4;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Testbench for if_fetch_stage: directed latency/stall/redirect/reset/wrap scenarios,
// then randomized stall, redirect and memory latency checked against a program-order
// model of the instruction stream ID should observe.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_stall;
  logic        if_id_valid;
  logic [31:0] if_id_instruction;
  logic [31:0] if_id_pc_plus4;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] req_addr = '0;

  always #5 clk = ~clk;

  if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .imem_req          (imem_req),
    .imem_addr         (imem_addr),
    .imem_rvalid       (imem_rvalid),
    .imem_rdata        (imem_rdata),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .id_stall          (id_stall),
    .if_id_valid       (if_id_valid),
    .if_id_instruction (if_id_instruction),
    .if_id_pc_plus4    (if_id_pc_plus4)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Instruction memory contents; address 0 holds 0x8C010004.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h8C01_0004;
  endfunction

  // Advance to the middle of the next cycle and note any request issued in it.
  task automatic cyc();
    @(negedge clk);
    #1;
    if (imem_req) req_addr = imem_addr;
  endtask

  task automatic drive(input logic st, input logic rd, input logic [31:0] rpc, input logic rv);
    id_stall       = st;
    redirect_valid = rd;
    redirect_pc    = rpc;
    imem_rvalid    = rv;
    imem_rdata     = rv ? mem_word(req_addr) : $urandom;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b0);
    cyc();
    cyc();
    rst_n = 1'b1;
    #1;
    if (imem_req) req_addr = imem_addr;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [31:0] pc4,
                           input logic [31:0] ins);
    check_eq({tag, "_valid"}, 32'(if_id_valid), 32'(v));
    check_eq({tag, "_pc4"}, if_id_pc_plus4, pc4);
    check_eq({tag, "_instr"}, if_id_instruction, ins);
  endtask

  task automatic check_req(input string tag, input logic r, input logic [31:0] a);
    check_eq({tag, "_req"}, 32'(imem_req), 32'(r));
    if (r) check_eq({tag, "_addr"}, imem_addr, a);
  endtask

  // Random-phase state
  logic [31:0] exp_pc, ptgt, raddr, rpc;
  logic        armed, outst, st, rd, rv;
  int unsigned lat, idle, consumed;

  initial begin
    // Reset values
    rst_n = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b0);
    cyc();
    cyc();
    check_out("reset", 1'b0, 32'h0, 32'h0);
    check_eq("reset_req", 32'(imem_req), 32'h0);
    check_eq("reset_addr", imem_addr, 32'h0);

    // First fetch latency
    rst_n = 1'b1;
    #1;
    if (imem_req) req_addr = imem_addr;
    check_req("first", 1'b1, 32'h0);
    drive(1'b0, 1'b0, '0, 1'b0);
    cyc(); check_req("wait", 1'b0, '0); drive(1'b0, 1'b0, '0, 1'b1);
    cyc(); check_out("t2", 1'b1, 32'h4, 32'h8C01_0004); check_req("t2", 1'b1, 32'h4);
    drive(1'b0, 1'b0, '0, 1'b0);

    // Stall for six cycles with two responses: output + skid, no requests while full
    cyc(); check_out("stall0", 1'b0, 32'h4, 32'h8C01_0004); drive(1'b1, 1'b0, '0, 1'b1);
    cyc(); check_out("stall1", 1'b1, 32'h8, mem_word(32'h4)); check_req("stall1", 1'b1, 32'h8);
    drive(1'b1, 1'b0, '0, 1'b0);
    cyc(); drive(1'b1, 1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(); check_req("skidfull", 1'b0, '0); check_out("hold", 1'b1, 32'h8, mem_word(32'h4));
      drive(1'b1, 1'b0, '0, 1'b0);
    end
    cyc(); check_req("skidfull_last", 1'b0, '0); drive(1'b0, 1'b0, '0, 1'b0);
    cyc(); check_out("unstall", 1'b1, 32'hC, mem_word(32'h8)); check_req("unstall", 1'b1, 32'hC);

    // Redirect to 0x100 while fetch 0x8 is in flight
    do_reset();
    check_req("r_first", 1'b1, 32'h0);
    drive(1'b0, 1'b0, '0, 1'b0);
    cyc(); drive(1'b0, 1'b0, '0, 1'b1);
    cyc(); drive(1'b0, 1'b0, '0, 1'b0);
    cyc(); drive(1'b0, 1'b0, '0, 1'b1);
    cyc(); check_out("r4", 1'b1, 32'h8, mem_word(32'h4)); check_req("r4", 1'b1, 32'h8);
    drive(1'b1, 1'b0, '0, 1'b0);
    cyc(); drive(1'b0, 1'b1, 32'h100, 1'b0);
    cyc(); check_eq("r6_valid", 32'(if_id_valid), 32'h0); drive(1'b0, 1'b0, '0, 1'b1);
    cyc();
`ifdef DELAY_SLOT_EN
    check_out("slot", 1'b1, 32'hC, mem_word(32'h8));
`else
    check_eq("squash_valid", 32'(if_id_valid), 32'h0);
`endif
    check_req("r7", 1'b1, 32'h100);
    drive(1'b0, 1'b0, '0, 1'b0);
    cyc(); drive(1'b0, 1'b0, '0, 1'b1);
    cyc(); check_out("target", 1'b1, 32'h104, mem_word(32'h100)); check_req("r9", 1'b1, 32'h104);
    drive(1'b1, 1'b0, '0, 1'b0);

    // Reset while a request is outstanding and output is live
    cyc();
    rst_n = 1'b0;
    #1;
    check_out("midreset", 1'b0, 32'h0, 32'h0);
    check_req("midreset", 1'b0, '0);
    check_eq("midreset_addr", imem_addr, 32'h0);
    drive(1'b0, 1'b0, '0, 1'b0);
    cyc();
    rst_n = 1'b1;
    #1;
    if (imem_req) req_addr = imem_addr;
    check_req("postreset", 1'b1, 32'h0);
    drive(1'b0, 1'b0, '0, 1'b1);
    imem_rdata = 32'hDEAD_BEEF;
    cyc(); check_eq("late_rvalid_valid", 32'(if_id_valid), 32'h0); check_req("late", 1'b0, '0);
    drive(1'b0, 1'b0, '0, 1'b1);
    cyc(); check_out("post_first", 1'b1, 32'h4, 32'h8C01_0004);

    // Redirect to the top of the address space: pc_plus4 wraps to zero
    drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    cyc(); drive(1'b0, 1'b0, '0, 1'b1);
    cyc();
`ifdef DELAY_SLOT_EN
    check_out("wrap_slot", 1'b1, 32'h8, mem_word(32'h4));
`else
    check_eq("wrap_squash", 32'(if_id_valid), 32'h0);
`endif
    check_req("wrap_req", 1'b1, 32'hFFFF_FFFC);
    drive(1'b0, 1'b0, '0, 1'b0);
    cyc(); drive(1'b0, 1'b0, '0, 1'b1);
    cyc(); check_out("wrap", 1'b1, 32'h0, mem_word(32'hFFFF_FFFC)); check_req("wrap_next", 1'b1, 32'h0);
    drive(1'b0, 1'b0, '0, 1'b0);

    // Randomized run against a program-order model
    do_reset();
    exp_pc = 32'h0; armed = 1'b0; outst = 1'b0; lat = 0; idle = 0; consumed = 0; raddr = '0;
    for (int c = 0; c < 3000; c++) begin
      if (c != 0) cyc();
      if (outst) check_eq("single_outstanding", 32'(imem_req), 32'h0);
      if (if_id_valid) begin
        check_eq("rnd_pc4", if_id_pc_plus4, exp_pc + 32'd4);
        check_eq("rnd_instr", if_id_instruction, mem_word(exp_pc));
      end
      st  = ($urandom_range(0, 99) < 30);
      rd  = 1'b0;
      rpc = '0;
      if (if_id_valid && !st && !armed && ($urandom_range(0, 99) < 12)) begin
        rd  = 1'b1;
        rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      end
      rv = 1'b0;
      if (outst) begin
        if (lat == 0) begin
          rv    = 1'b1;
          outst = 1'b0;
        end else begin
          lat--;
        end
      end
      id_stall       = st;
      redirect_valid = rd;
      redirect_pc    = rpc;
      imem_rvalid    = rv;
      imem_rdata     = rv ? mem_word(raddr) : $urandom;
      if (imem_req) begin
        outst = 1'b1;
        raddr = imem_addr;
        lat   = $urandom_range(0, 2);
      end
      if (if_id_valid && !st) begin
        consumed++;
        idle = 0;
        if (armed) begin
          exp_pc = ptgt;
          armed  = 1'b0;
        end else if (rd) begin
`ifdef DELAY_SLOT_EN
          exp_pc = exp_pc + 32'd4;
          armed  = 1'b1;
          ptgt   = rpc;
`else
          exp_pc = rpc;
`endif
        end else begin
          exp_pc = exp_pc + 32'd4;
        end
      end else begin
        idle++;
      end
      if (idle > 200) begin
        check_eq("watchdog_idle", 32'(idle), 32'h0);
        break;
      end
    end
    check_eq("progress", 32'(consumed >= 300), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
